// File: rtl/iecdrv_rom_arbiter_if.sv
// Bus bundle for iecdrv_rom_arbiter: requester ports,
// shared ROM address/data and status.
interface iecdrv_rom_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int NBANK = 4,
  parameter int AW    = 15
);
  localparam int PW = (AW > 13) ? AW - 13 : 1;

  logic                     start;
  logic [NREQ-1:0]          req_en;
  logic [NREQ-1:0][AW-1:0]  req_addr;
  logic [NREQ-1:0][1:0]     req_bank;
  logic [NBANK-1:0][PW-1:0] bank_sz;
  logic [AW-1:0]            mem_a;
  logic [NBANK-1:0][7:0]    rom_q;
  logic [NREQ-1:0][7:0]     req_data;
  logic [NREQ-1:0]          req_valid;
  logic                     overrun;

  modport master (
    output start, req_en, req_addr, req_bank,
    output bank_sz, rom_q,
    input  mem_a, req_data, req_valid, overrun
  );

  modport slave (
    input  start, req_en, req_addr, req_bank,
    input  bank_sz, rom_q,
    output mem_a, req_data, req_valid, overrun
  );
endinterface

// File: rtl/iecdrv_rom_arbiter.sv
// Time-slot arbiter sharing drive ROM banks among NREQ drive CPUs.
// Define IECDRV_ROM_ARB_SKIP_IDLE_EN to pack slots over enabled requesters.
module iecdrv_rom_arbiter #(
  parameter int NREQ   = 4,
  parameter int NBANK  = 4,
  parameter int AW     = 15,
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic reset,
  iecdrv_rom_arbiter_if.slave bus
);
  localparam int SAT = NREQ + RD_LAT;
  localparam int CW  = $clog2(SAT + 1);
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW  = (AW > 13) ? AW - 13 : 1;

  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t IDLE = cnt_t'(SAT);

  cnt_t          cnt;
  cnt_t          cnt_inc;
  cnt_t          lim;
  cnt_t          first;
  logic          issue;
  logic          early;
  logic [IW-1:0] sel;

  logic [1:0]    bank_s;
  logic [PW-1:0] mask_s;
  logic [AW-1:0] addr_s;

  logic [RD_LAT-1:0]         pv;
  logic [RD_LAT-1:0][IW-1:0] pidx;
  logic [RD_LAT-1:0][1:0]    pbank;

  logic [IW-1:0] cap_idx;
  logic [1:0]    cap_bank;
  logic [7:0]    cap_q;

  logic [AW-1:0]         mem_a_q;
  logic [NREQ-1:0][7:0]  data_q;
  logic [NREQ-1:0]       valid_q;
  logic                  ovr_q;

  assign cnt_inc = cnt + cnt_t'(1);

`ifdef IECDRV_ROM_ARB_SKIP_IDLE_EN
  logic [NREQ-1:0] en_q;
  cnt_t            n_q;
  cnt_t            n_new;
  cnt_t            seen;

  always_comb begin
    n_new = '0;
    for (int i = 0; i < NREQ; i++)
      n_new = n_new + cnt_t'(bus.req_en[i]);
  end

  // slot cnt maps to the cnt-th enabled requester
  always_comb begin
    seen = '0;
    sel  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (en_q[i]) begin
        if (seen == cnt) sel = IW'(i);
        seen = seen + cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q <= '0;
      n_q  <= '0;
    end else if (bus.start) begin
      en_q <= bus.req_en;
      n_q  <= n_new;
    end
  end

  assign issue = cnt < n_q;
  assign lim   = n_q + cnt_t'(RD_LAT);
  assign first = (n_new == '0) ? IDLE : '0;
`else
  logic unused_en;
  assign unused_en = ^bus.req_en;
  assign sel       = IW'(cnt);
  assign issue     = cnt < cnt_t'(NREQ);
  assign lim       = IDLE;
  assign first     = '0;
`endif

  // start before the last capture of the window
  assign early = bus.start && (cnt != IDLE) && (cnt_inc < lim);

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= IDLE;
    else if (bus.start)
      cnt <= first;
    else if (cnt != IDLE)
      cnt <= (cnt_inc >= lim) ? IDLE : cnt_inc;
  end

  assign bank_s = bus.req_bank[sel];
  assign mask_s = (int'(bank_s) < NBANK) ? bus.bank_sz[bank_s] : '1;

  if (AW > 13) begin : g_page
    assign addr_s = {bus.req_addr[sel][AW-1:13] & mask_s,
                     bus.req_addr[sel][12:0]};
  end else begin : g_flat
    logic unused_mask;
    assign unused_mask = ^mask_s;
    assign addr_s      = bus.req_addr[sel];
  end

  // start flushes everything still in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      pv    <= '0;
      pidx  <= '0;
      pbank <= '0;
    end else begin
      pv[0]    <= issue & ~bus.start;
      pidx[0]  <= sel;
      pbank[0] <= bank_s;
      for (int s = 1; s < RD_LAT; s++) begin
        pv[s]    <= pv[s-1] & ~bus.start;
        pidx[s]  <= pidx[s-1];
        pbank[s] <= pbank[s-1];
      end
    end
  end

  assign cap_idx  = pidx[RD_LAT-1];
  assign cap_bank = pbank[RD_LAT-1];
  assign cap_q    = (int'(cap_bank) < NBANK) ?
                    bus.rom_q[cap_bank] : 8'hFF;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_a_q <= '0;
      data_q  <= {NREQ{8'hFF}};
      valid_q <= '0;
      ovr_q   <= 1'b0;
    end else begin
      if (issue) mem_a_q <= addr_s;
      valid_q <= '0;
      if (pv[RD_LAT-1]) begin
        data_q[cap_idx]  <= cap_q;
        valid_q[cap_idx] <= 1'b1;
      end
      if (early) ovr_q <= 1'b1;
    end
  end

  assign bus.mem_a     = mem_a_q;
  assign bus.req_data  = data_q;
  assign bus.req_valid = valid_q;
  assign bus.overrun   = ovr_q;
endmodule

// File: tb/tb_iecdrv_rom_arbiter.sv
// Bench for iecdrv_rom_arbiter: directed scenarios plus random traffic
// against a slot-schedule reference model.
module tb_iecdrv_rom_arbiter;
  localparam int NREQ   = 4;
  localparam int NBANK  = 4;
  localparam int AW     = 15;
  localparam int RD_LAT = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  iecdrv_rom_arbiter_if #(
    .NREQ(NREQ), .NBANK(NBANK), .AW(AW)
  ) bus ();

  iecdrv_rom_arbiter #(
    .NREQ(NREQ), .NBANK(NBANK), .AW(AW), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] romval(int b, logic [AW-1:0] a);
    return 8'(a) ^ 8'(a >> 7) ^ 8'(b * 91 + 17);
  endfunction

  // ROM banks: one register stage on the shared address
  logic [AW-1:0] rom_a = '0;
  always @(posedge clk) rom_a <= bus.mem_a;
  always_comb begin
    bus.rom_q = '0;
    for (int b = 0; b < NBANK; b++)
      bus.rom_q[b] = romval(b, rom_a);
  end

  typedef struct {
    int         due;
    int         req;
    logic [7:0] val;
  } cap_t;

  cap_t pend[$];
  int   order[$];
  int   pos = -1;

  logic [AW-1:0]        m_a;
  logic [NREQ-1:0][7:0] m_data;
  logic [NREQ-1:0]      m_valid;
  logic                 m_ovr;

  // advance the model across one clock edge using current inputs
  task automatic model_step();
    if (reset) begin
      pos = -1;
      pend.delete();
      order.delete();
      m_a     = '0;
      m_data  = {NREQ{8'hFF}};
      m_valid = '0;
      m_ovr   = 1'b0;
    end else begin
      m_valid = '0;
      for (int i = pend.size() - 1; i >= 0; i--) begin
        if (pend[i].due == pos) begin
          m_data[pend[i].req]  = pend[i].val;
          m_valid[pend[i].req] = 1'b1;
          pend.delete(i);
        end
      end
      if (pos >= 0 && pos < order.size()) begin
        int r;
        int b;
        int mk;
        int ai;
        logic [AW-1:0] a;
        logic [7:0] v;
        r  = order[pos];
        b  = int'(bus.req_bank[r]);
        mk = (b < NBANK) ? int'(bus.bank_sz[b]) : 'hFFFF;
        ai = int'(bus.req_addr[r]);
        a  = AW'((((ai >> 13) & mk) << 13) | (ai & 'h1FFF));
        v  = (b < NBANK) ? romval(b, a) : 8'hFF;
        m_a = a;
        pend.push_back('{due: pos + RD_LAT, req: r, val: v});
      end
      if (bus.start) begin
        if (pend.size() != 0) m_ovr = 1'b1;
        pend.delete();
        order.delete();
        for (int i = 0; i < NREQ; i++) begin
`ifdef IECDRV_ROM_ARB_SKIP_IDLE_EN
          if (bus.req_en[i]) order.push_back(i);
`else
          order.push_back(i);
`endif
        end
        pos = (order.size() != 0) ? 0 : -1;
      end else if (pos >= 0) begin
        pos++;
        if (pos >= order.size() + RD_LAT) pos = -1;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    check("mem_a", bus.mem_a, m_a);
    check("req_data", bus.req_data, m_data);
    check("req_valid", bus.req_valid, m_valid);
    check("overrun", bus.overrun, m_ovr);
  endtask

  logic [AW-1:0] seq [4];

  initial begin
    seq[0] = 15'h1000;
    seq[1] = 15'h2000;
    seq[2] = 15'h4000;
    seq[3] = 15'h7FFF;

    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.req_en   = '1;
    bus.req_addr = '0;
    bus.req_bank = '0;
    bus.bank_sz  = {NBANK{2'b11}};
    tick();
    tick();
    check("rst_mem_a", bus.mem_a, '0);
    check("rst_data", bus.req_data, {NREQ{8'hFF}});
    check("rst_valid", bus.req_valid, '0);
    check("rst_ovr", bus.overrun, '0);
    reset = 1'b0;

    // basic window, all banks 32K
    for (int i = 0; i < NREQ; i++) begin
      bus.req_addr[i] = seq[i];
      bus.req_bank[i] = 2'(i);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      tick();
      check("seq_mem_a", bus.mem_a, seq[k]);
    end
    repeat (4) tick();
    check("seq_d0", bus.req_data[0], romval(0, seq[0]));
    check("seq_d3", bus.req_data[3], romval(3, seq[3]));

    // page masking
    bus.bank_sz[1]  = 2'b00;
    bus.req_bank[0] = 2'd1;
    bus.req_addr[0] = 15'h7ABC;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check("mask_8k", bus.mem_a, 15'h1ABC);
    repeat (6) tick();
    bus.bank_sz[1] = 2'b01;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check("mask_16k", bus.mem_a, 15'h3ABC);
    repeat (6) tick();

    // overrun: second start three cycles after the first
    bus.bank_sz = {NBANK{2'b11}};
    for (int i = 0; i < NREQ; i++) begin
      bus.req_addr[i] = AW'(16'h0111 * (i + 3));
      bus.req_bank[i] = 2'(NREQ - 1 - i);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("ovr_set", bus.overrun, 1'b1);
    check("ovr_valid0", bus.req_valid, 4'b0001);
    repeat (8) tick();

    // reset in the middle of a window
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_data", bus.req_data, {NREQ{8'hFF}});
    check("mid_rst_ovr", bus.overrun, '0);
    check("mid_rst_mem_a", bus.mem_a, '0);
    repeat (6) tick();
    check("mid_rst_hold", bus.req_data, {NREQ{8'hFF}});

    // bank switch after slot-0 issue
    bus.req_bank[0] = 2'd0;
    bus.req_addr[0] = 15'h0123;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.req_bank[0] = 2'd2;
    repeat (6) tick();
    check("bank_hold", bus.req_data[0], romval(0, 15'h0123));

`ifdef IECDRV_ROM_ARB_SKIP_IDLE_EN
    bus.req_en = 4'b1010;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    repeat (8) tick();
    bus.req_en = '1;
`endif

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 99) == 0);
      bus.start = ($urandom_range(0, 6) == 0);
      bus.req_en = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        bus.req_addr[i] = AW'($urandom);
        if ($urandom_range(0, 2) == 0)
          bus.req_bank[i] = 2'($urandom);
      end
      if ($urandom_range(0, 15) == 0)
        for (int b = 0; b < NBANK; b++)
          bus.bank_sz[b] = 2'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
